// File: rtl/ddr_tx_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer_pkg
//
// Shared definitions for the DDR transmit serializer:
//   TX_IDLE_WORD  - default filler word sent when no data is accepted
//   TX_SYNC_WORD  - default alignment word (only used with TX_SYNC_EN)
//   beatWidth()   - width of the beat counter, clog2(W/2) but never below 1
//   paramsLegal() - parameter sanity check (even width >= 2, sync period >= 2)
// ---------------------------------------------------------------------------
package ddr_tx_serializer_pkg;

    localparam logic [15:0] TX_IDLE_WORD = 16'hBC50;
    localparam logic [15:0] TX_SYNC_WORD = 16'hF628;

    // A 2-bit word has a single beat, which still needs a 1-bit counter
    // so the rest of the datapath keeps a uniform shape.
    function automatic int beatWidth(input int dataWidth);
        int w;
        w = $clog2(dataWidth / 2);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit paramsLegal(input int dataWidth, input int syncPeriod);
        return (dataWidth >= 2) && ((dataWidth % 2) == 0) && (syncPeriod >= 2);
    endfunction

endpackage

// File: rtl/ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer
//
// Parallel-to-DDR transmit serializer feeding an ODDR/OBUFDS pair (the ODDR
// itself lives in the parent). Words are accepted over a valid/ready
// handshake and shifted out MSB-first, two bits per clk: d1 feeds the
// rising-edge ODDR input, d2 the falling-edge input. When nothing is offered
// an idle word is sent so the link stays continuous and word-aligned.
//
// Optional feature: define TX_SYNC_EN to insert SYNC_WORD as the first word
// after reset and then once every SYNC_PERIOD words.
//
// Ports:
//   clk        in   clock, also the ODDR C input
//   rst        in   asynchronous active-high reset
//   din        in   [DATA_WIDTH] word to transmit
//   din_valid  in   din is valid
//   din_ready  out  word accepted on this edge if din_valid is high
//   d1         out  bit for ODDR D1 (rising edge)
//   d2         out  bit for ODDR D2 (falling edge)
//   word_start out  high during the first beat of every emitted word
//   data_flag  out  high during every beat of a word taken from din
//   data_count out  [32] data words accepted since reset, wraps
// ---------------------------------------------------------------------------
module ddr_tx_serializer
    import ddr_tx_serializer_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(TX_IDLE_WORD),
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(TX_SYNC_WORD),
    parameter int                    SYNC_PERIOD = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  d1,
    output logic                  d2,
    output logic                  word_start,
    output logic                  data_flag,
    output logic [31:0]           data_count
);

    localparam int            BW   = beatWidth(DATA_WIDTH);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH / 2 - 1);

    // Elaboration-time guard against unusable parameter sets.
    if (!paramsLegal(DATA_WIDTH, SYNC_PERIOD) || ($bits(SYNC_WORD) != DATA_WIDTH)) begin : gBadParams
        $error("ddr_tx_serializer: DATA_WIDTH must be even and >= 2, SYNC_PERIOD must be >= 2");
    end

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  wordStart_q, wordStart_d;
    logic                  dataFlag_q, dataFlag_d;
    logic [31:0]           dataCount_q, dataCount_d;

    logic beatLast;
    logic syncDue;
    logic transfer;

    // The wrap beat is the only point where a new word can be loaded, so
    // ready is purely a function of internal state and never of din_valid.
    assign beatLast  = (beat_q == LAST);
    assign din_ready = beatLast && !syncDue;
    assign transfer  = din_valid && din_ready;

`ifdef TX_SYNC_EN
    localparam int SW = $clog2(SYNC_PERIOD);

    logic [SW-1:0] syncCnt_q, syncCnt_d;

    // Every load (sync, data or idle) advances the period counter; a count
    // of zero means the next load must be the alignment word.
    assign syncDue = (syncCnt_q == '0);

    always_comb begin
        syncCnt_d = syncCnt_q;
        if (beatLast) begin
            if (syncCnt_q == SW'(SYNC_PERIOD - 1)) begin
                syncCnt_d = '0;
            end else begin
                syncCnt_d = syncCnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncCnt_q <= '0;
        end else begin
            syncCnt_q <= syncCnt_d;
        end
    end
`else
    assign syncDue = 1'b0;
`endif

    // Shift two bits per beat; on the wrap beat load the next word with
    // priority sync > data > idle and mark the first beat of the new word.
    always_comb begin
        shreg_d     = shreg_q << 2;
        beat_d      = beat_q + BW'(1);
        wordStart_d = 1'b0;
        dataFlag_d  = dataFlag_q;
        dataCount_d = dataCount_q;
        if (transfer) begin
            dataCount_d = dataCount_q + 32'd1;
        end
        if (beatLast) begin
            beat_d      = '0;
            wordStart_d = 1'b1;
            if (syncDue) begin
`ifdef TX_SYNC_EN
                shreg_d = SYNC_WORD;
`else
                shreg_d = IDLE_WORD;
`endif
                dataFlag_d = 1'b0;
            end else if (transfer) begin
                shreg_d    = din;
                dataFlag_d = 1'b1;
            end else begin
                shreg_d    = IDLE_WORD;
                dataFlag_d = 1'b0;
            end
        end
    end

    // Reset parks the beat counter on LAST so the first edge after reset
    // release is already a load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            beat_q      <= LAST;
            wordStart_q <= 1'b0;
            dataFlag_q  <= 1'b0;
            dataCount_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            beat_q      <= beat_d;
            wordStart_q <= wordStart_d;
            dataFlag_q  <= dataFlag_d;
            dataCount_q <= dataCount_d;
        end
    end

    assign d1         = shreg_q[DATA_WIDTH-1];
    assign d2         = shreg_q[DATA_WIDTH-2];
    assign word_start = wordStart_q;
    assign data_flag  = dataFlag_q;
    assign data_count = dataCount_q;

endmodule

// File: doc/ddr_tx_serializer.md
# ddr_tx_serializer

Parallel-to-DDR transmit serializer that feeds an ODDR/OBUFDS output pair. It accepts words over a valid/ready handshake and emits them MSB-first, two bits per `clk` cycle on `d1`/`d2`. `d1` maps to the ODDR rising-edge input and `d2` to the falling-edge input. When no data is offered it fills the link with an idle word, so the far end always sees a continuous word-aligned stream.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width; must be even and ≥ 2.
- `IDLE_WORD`, 16'hBC50: word emitted when no data is accepted.
- `SYNC_WORD`, 16'hF628: alignment word; used only with `TX_SYNC_EN`.
- `SYNC_PERIOD`, 64: words per sync interval, ≥ 2; used only with `TX_SYNC_EN`.

Ports:
- `clk`  in  1: single clock; also drives the ODDR `C`.
- `rst`  in  1: reset, asynchronous and active-high.
- `din`  in  DATA_WIDTH: word to transmit.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: the serializer accepts `din` this cycle.
- `d1`  out  1: bit for the ODDR `D1` (rising edge).
- `d2`  out  1: bit for the ODDR `D2` (falling edge).
- `word_start`  out  1: high during the first beat of every emitted word.
- `data_flag`  out  1: high during every beat of a word that came from `din`.
- `data_count`  out  32: number of data words accepted since reset; wraps modulo 2^32.

## Operation
- Shift register `shreg[DATA_WIDTH-1:0]`, with `d1 = shreg[W-1]` and `d2 = shreg[W-2]`. Each beat shifts left by 2.
- Beat counter `beat` counts 0 … LAST, where LAST = W/2−1. It wraps to 0 after LAST, and a new word loads on that wrap edge.
- Handshake: `din_ready = (beat == LAST) && !sync_due`. A transfer occurs when `din_valid && din_ready` at a rising edge.
  - `din_ready` depends only on internal state, never on `din_valid`.
  - `din_valid` may rise or fall freely; there is no holding requirement when `din_ready` is low.
- Load priority at the wrap edge:
  1. `sync_due` → `SYNC_WORD`.
  2. Otherwise, a transfer → `din`, with `data_flag` = 1 for the whole word.
  3. Otherwise → `IDLE_WORD`, with `data_flag` = 0.
- `word_start` = 1 whenever `beat` = 0 after a load.
- `data_count` increments by 1 on each transfer.
- With W = 2, LAST = 0: every cycle is a wrap, and `din_ready` is high every cycle that is not sync-due.
- There are no implicit states beyond `beat`, `shreg`, `data_flag` and the sync counter. No FSM is required.

## Timing
- Reset values:
  - `shreg` = 0, so `d1` = `d2` = 0.
  - `beat` = LAST, so `din_ready` = 1 in the first cycle after reset deassertion. Without `TX_SYNC_EN` it follows the rule above; with it, see Configuration.
  - `word_start` = 0, `data_flag` = 0, `data_count` = 0.
  - Sync counter = 0.
- Latency: a word transferred at edge N appears with its MSB pair on `d1`/`d2` in the cycle following edge N. Its last pair appears W/2−1 cycles later.
- Throughput: one word per W/2 cycles, with no bubbles while `din_valid` is held.
- Asserting reset mid-word abandons the word immediately. Outputs return to reset values asynchronously, and the word is not counted unless its transfer edge has already occurred.

## Configuration
- `TX_SYNC_EN` defined:
  - A load counter `sync_cnt` runs 0 … SYNC_PERIOD−1 and advances on every load.
  - `sync_due = (sync_cnt == 0)`, so the first word after reset is `SYNC_WORD`, followed by one sync every SYNC_PERIOD words.
  - Idle and data loads both count toward the period.
  - `din_ready` is low on sync-due wraps; `data_flag` = 0 during sync words.
- `TX_SYNC_EN` undefined: `sync_due` is constant 0, `sync_cnt` and the `SYNC_*` parameters are unused, and no logic is generated for them.

## Structure
- Shared package/include holds:
  - default word constants `TX_IDLE_WORD` and `TX_SYNC_WORD`;
  - the `beat` width function, `clog2(W/2)` with a minimum of 1;
  - the parameter legality checks (even W, SYNC_PERIOD ≥ 2).
- The design is a single flat module with no sub-modules. The ODDR/OBUFDS instantiation sits in the parent.

## Test plan
- Idle (W=8, IDLE 8'h3C, no sync): after reset, hold `din_valid` low → `d1`/`d2` pairs repeat (0,0),(1,1),(1,1),(0,0); `word_start` is high every 4th cycle; `data_flag` = 0.
- Single word (W=8): `din` = 8'hB4 accepted at the first ready → next 4 cycles give (1,0),(1,1),(0,1),(0,0) with `data_flag` = 1; `data_count` = 1; idle follows.
- Back-to-back (W=16): hold `din_valid` high for 10 words → one transfer every 8 cycles, no idle word in between, `data_count` = 10.
- Valid toggling: `din_valid` pulses on non-LAST beats only → no transfer and `data_count` unchanged.
- Sync (`TX_SYNC_EN`, SYNC_PERIOD=4): continuous valid → word sequence SYNC,D,D,D,SYNC,…; `din_ready` stays low on the sync wraps.
- Reset mid-word (W=16): assert `rst` at beat 3 → `d1`/`d2`/`data_flag` go to 0 immediately; after release, `din_ready` = 1 (no sync) or a sync word is sent first (`TX_SYNC_EN`).
